// File: rtl/lbm_macro_streamer.sv
// Captures per-cell macroscopic samples from the LBM collider, tags them with frame/row markers
// and streams them through a small FIFO. Optional frame decimation is enabled by STREAM_DECIMATE_EN.
module lbm_macro_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int GRID_W     = 50,
  parameter int GRID_H     = 50,
  parameter int FIFO_DEPTH = 16,
  parameter int DECIMATION = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    collider_ready,
  input  logic [DATA_WIDTH-1:0]   u_x,
  input  logic [DATA_WIDTH-1:0]   u_y,
  input  logic [DATA_WIDTH-1:0]   rho,
  input  logic [DATA_WIDTH-1:0]   u_squared,
  output logic [4*DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_sof,
  output logic                    m_eol,
  output logic [15:0]             frame_count,
  output logic                    overflow
);

  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 * DATA_WIDTH + 2;

`ifdef STREAM_DECIMATE_EN
  localparam bit DECIM_ON = 1'b1;
`else
  localparam bit DECIM_ON = 1'b0;
`endif
  localparam int DEC_EFF = DECIM_ON ? DECIMATION : 1;

  // Stream handshake: a word transfers on every cycle with m_valid & m_ready; while m_valid is
  // high and m_ready low, m_data/m_sof/m_eol are held unchanged.

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] count, count_next, remaining;
  logic          sample, x_last, y_last, emit_frame, full, pop, push, drop;
  logic [EW-1:0] entry, head_next;

  assign sample     = collider_ready & en;
  assign x_last     = (x == XW'(GRID_W - 1));
  assign y_last     = (y == YW'(GRID_H - 1));
  assign emit_frame = ((32'(frame_count) % DEC_EFF) == 0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = m_valid & m_ready;
  assign push       = sample & emit_frame & (~full | pop);
  assign drop       = sample & emit_frame & full & ~pop;
  assign entry      = {rho, u_x, u_y, u_squared, (x == '0) && (y == '0), x_last};

  assign count_next = count + CW'(push) - CW'(pop);
  assign remaining  = count - CW'(pop);
  assign rd_next    = rd_ptr + AW'(pop);

  // Next presented word: the next stored entry, else the word being written into an empty FIFO,
  // else hold whatever was last shown.
  always_comb begin
    head_next = {m_data, m_sof, m_eol};
    if (remaining != '0) begin
      head_next = mem[rd_next];
    end else if (push) begin
      head_next = entry;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      frame_count <= '0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_sof       <= 1'b0;
      m_eol       <= 1'b0;
    end else begin
      // Position tracks the solver scan order even for dropped samples.
      if (sample) begin
        if (x_last) begin
          x <= '0;
          if (y_last) begin
            y           <= '0;
            frame_count <= frame_count + 16'd1;
          end else begin
            y <= y + YW'(1);
          end
        end else begin
          x <= x + XW'(1);
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr                 <= rd_next;
      count                  <= count_next;
      m_valid                <= (count_next != '0);
      {m_data, m_sof, m_eol} <= head_next;
    end
  end

endmodule

// File: tb/tb_lbm_macro_streamer.sv
// Bench for lbm_macro_streamer: queue-based reference model checked every cycle, plus directed
// scenarios with literal expectations (reset, latency, overflow, full+pop, mid-frame reset).
module tb_lbm_macro_streamer;

  localparam int DW    = 16;
  localparam int GW    = 50;
  localparam int GH    = 50;
  localparam int FD    = 16;
  localparam int DEC   = 4;
  localparam int CELLS = GW * GH;

  logic          clk = 1'b0;
  logic          rst, en, collider_ready, m_ready;
  logic [DW-1:0] u_x, u_y, rho, u_squared;
  logic [63:0]   m_data;
  logic          m_valid, m_sof, m_eol, overflow;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  lbm_macro_streamer #(
    .DATA_WIDTH(DW), .GRID_W(GW), .GRID_H(GH), .FIFO_DEPTH(FD), .DECIMATION(DEC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .collider_ready(collider_ready),
    .u_x(u_x), .u_y(u_y), .rho(rho), .u_squared(u_squared),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .frame_count(frame_count), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries are {rho,u_x,u_y,u_squared,sof,eol}.
  logic [65:0] exp_q[$];
  int          m_cell = 0;
  logic [15:0] m_fc   = '0;
  logic        m_ovf  = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    bit popped, emit;
    if (rst) begin
      exp_q.delete();
      m_cell = 0;
      m_fc   = '0;
      m_ovf  = 1'b0;
    end else begin
      popped = (exp_q.size() != 0) && m_ready;
      if (popped) void'(exp_q.pop_front());
      if (collider_ready && en) begin
        emit = 1'b1;
`ifdef STREAM_DECIMATE_EN
        emit = ((m_fc % DEC) == 0);
`endif
        if (emit) begin
          if (exp_q.size() < FD)
            exp_q.push_back({rho, u_x, u_y, u_squared, (m_cell == 0), ((m_cell % GW) == GW - 1)});
          else
            m_ovf = 1'b1;
        end
        m_cell++;
        if (m_cell == CELLS) begin
          m_cell = 0;
          m_fc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("m_valid", m_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("m_data", m_data, exp_q[0][65:2]);
        check("m_sof", m_sof, exp_q[0][1]);
        check("m_eol", m_eol, exp_q[0][0]);
      end
      check("frame_count", frame_count, m_fc);
      check("overflow", overflow, m_ovf);
    end
  end

  // Words actually accepted by the consumer: {m_data,m_sof,m_eol}.
  logic [65:0] got_q[$];
  always @(posedge clk) begin
    if (!rst && m_valid && m_ready) got_q.push_back({m_data, m_sof, m_eol});
  end

  task automatic drive_cell(input logic [15:0] r, input logic [15:0] ux,
                            input logic [15:0] uy, input logic [15:0] us);
    en = 1'b1; collider_ready = 1'b1;
    rho = r; u_x = ux; u_y = uy; u_squared = us;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    collider_ready = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; collider_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_sof, n_eol, ord_err;
    logic [65:0] w;
    rst = 1'b1; en = 1'b0; collider_ready = 1'b0; m_ready = 1'b0;
    rho = '0; u_x = '0; u_y = '0; u_squared = '0;
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_sof", m_sof, 0);
    check("rst_m_eol", m_eol, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // One full frame at full throughput.
    m_ready = 1'b1;
    for (int i = 0; i < CELLS; i++)
      drive_cell(16'(i), 16'($urandom), 16'($urandom), 16'($urandom_range(0, 255)));
    idle(4);
    check("t1_words", got_q.size(), 2500);
    n_sof = 0; n_eol = 0; ord_err = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      w = got_q[k];
      if (w[1]) begin n_sof++; if (k != 0) ord_err++; end
      if (w[0]) begin n_eol++; if ((k % 50) != 49) ord_err++; end
      if (w[65:50] != 16'(k)) ord_err++;
    end
    check("t1_sof_count", n_sof, 1);
    check("t1_eol_count", n_eol, 50);
    check("t1_order", ord_err, 0);
    check("t1_frame_count", frame_count, 1);

    // en low: collider strobes are ignored.
    got_q.delete();
    en = 1'b0; collider_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("en_low_words", got_q.size(), 0);

    // Single sample latency and packing.
    m_ready = 1'b0;
    drive_cell(16'h1000, 16'h0010, 16'hFFF0, 16'h0002);
    collider_ready = 1'b0;
    check("t2_valid", m_valid, 1);
    check("t2_data", m_data, 64'h1000_0010_FFF0_0002);
    check("t2_sof", m_sof, 1);
    idle(3);
    check("t2_hold", m_data, 64'h1000_0010_FFF0_0002);
    m_ready = 1'b1;
    idle(2);

    // Overflow with the consumer stalled.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) drive_cell(16'(i), 16'h1, 16'h2, 16'h3);
    collider_ready = 1'b0;
    check("t3_overflow", overflow, 1);
    check("t3_valid", m_valid, 1);
    m_ready = 1'b1;
    idle(20);
    check("t3_words", got_q.size(), 16);
    ord_err = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      w = got_q[k];
      if (w[65:50] != 16'(k)) ord_err++;
    end
    check("t3_order", ord_err, 0);
    check("t3_drained", m_valid, 0);

    // Full FIFO with pop and push in the same cycle.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) drive_cell(16'(i), 16'h4, 16'h5, 16'h6);
    check("t4_full_no_ovf", overflow, 0);
    m_ready = 1'b1;
    drive_cell(16'd16, 16'h4, 16'h5, 16'h6);
    idle(20);
    check("t4_overflow", overflow, 0);
    check("t4_words", got_q.size(), 17);
    ord_err = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      w = got_q[k];
      if (w[65:50] != 16'(k)) ord_err++;
    end
    check("t4_order", ord_err, 0);

    // Reset mid-frame, then resume.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i <= 777; i++) drive_cell(16'(i), 16'h7, 16'h8, 16'h9);
    do_reset();
    for (int i = 0; i < 3; i++) drive_cell(16'(i), 16'hA, 16'hB, 16'hC);
    idle(4);
    check("t5_words", got_q.size(), 3);
    w = got_q[0];
    check("t5_first_sof", w[1], 1);
    check("t5_first_rho", w[65:50], 0);
    check("t5_frame_count", frame_count, 0);
    check("t5_overflow", overflow, 0);

    // Random gaps and backpressure, checked by the model.
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0)
        drive_cell(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      else
        idle(1);
    end
    m_ready = 1'b1;
    idle(20);
    check("t6_drained", m_valid, 0);

`ifdef STREAM_DECIMATE_EN
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5 * CELLS; i++) drive_cell(16'(i % CELLS), 16'h1, 16'h2, 16'h3);
    idle(4);
    check("t7_words", got_q.size(), 5000);
    check("t7_overflow", overflow, 0);
    check("t7_frame_count", frame_count, 5);
    n_sof = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      w = got_q[k];
      if (w[1]) n_sof++;
    end
    check("t7_sof_count", n_sof, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
